pc_sequencer: RTL and testbench

Parametrised program-counter and trap sequencer for the RISC-V controller. It generalises the fixed 8-bit PC+4 path to full next-PC selection: stall, conditional branch from ALU flags, JAL and JALR link, interrupt entry with sepc save, and trap return. It sits between the controller's decode logic and the instruction memory. It drives pc_ to the `inst` memory, which registers it internally, and holds the architectural pc.

---
 rtl/rv_ctrl_pkg.sv | 24 ++
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/branch_cond.sv | 26 ++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared controller definitions: branch funct3 codes, sequencer states
// and the base opcodes the decode logic and pc_sequencer agree on.
package rv_ctrl_pkg;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   typedef enum logic {RUN, HANDLER} seq_state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/pc_sequencer_if.sv
// Controller <-> pc_sequencer bundle.
// master: decode side (drives control/flags, reads pc/link/trap state).
// slave : pc_sequencer.
interface pc_sequencer_if #(
   parameter int NBITS = 8
);

   logic             busy;
   logic             interrupt;
   logic             Branch;
   logic [2:0]       funct3;
   logic             Zero;
   logic             Neg;
   logic             Carry;
   logic             ju;
   logic             jr;
   logic             tret;
   logic [NBITS-1:0] IMM;
   logic [NBITS-1:0] PCReg;
   logic [NBITS-1:0] pc;
   logic [NBITS-1:0] pc_;
   logic [NBITS-1:0] pclink;
   logic             link;
   logic [NBITS-1:0] sepc;
   logic             in_handler;
   logic             pending;

   modport master (
      output busy, interrupt, Branch, funct3,
      output Zero, Neg, Carry, ju, jr, tret,
      output IMM, PCReg,
      input  pc, pc_, pclink, link, sepc,
      input  in_handler, pending
   );

   modport slave (
      input  busy, interrupt, Branch, funct3,
      input  Zero, Neg, Carry, ju, jr, tret,
      input  IMM, PCReg,
      output pc, pc_, pclink, link, sepc,
      output in_handler, pending
   );

endinterface

// File: rtl/branch_cond.sv
// Branch condition evaluator from ALU flags.
// Ports: funct3, Zero, Neg, Carry (1 = no borrow) in; taken out.
module branch_cond
   import rv_ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       Zero,
   input  logic       Neg,
   input  logic       Carry,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      unique case (funct3)
         BEQ:     taken = Zero;
         BNE:     taken = ~Zero;
         BLT:     taken = Neg;
         BGE:     taken = ~Neg;
         BLTU:    taken = ~Carry;
         BGEU:    taken = Carry;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection and single-level trap sequencer.
// Ports: clock, reset (sync, active high); bus = pc_sequencer_if.slave.
module pc_sequencer
   import rv_ctrl_pkg::*;
#(
   parameter int          NBITS    = 8,
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter logic [31:0] IVEC     = 32'h40,
   parameter int          ISTEP    = 4,
   parameter int          IRQ_EDGE = 0
) (
   input logic           clock,
   input logic           reset,
   pc_sequencer_if.slave bus
);

   localparam logic [NBITS-1:0] PC_RST = NBITS'(RESET_PC);
   localparam logic [NBITS-1:0] VEC    = NBITS'(IVEC);
   localparam logic [NBITS-1:0] STEP   = NBITS'(ISTEP);
   localparam logic [NBITS-1:0] BIT0   = NBITS'(1);

   seq_state_t       state;
   seq_state_t       state_n;
   logic [NBITS-1:0] pc;
   logic [NBITS-1:0] pc_n;
   logic [NBITS-1:0] sepc;
   logic [NBITS-1:0] pc_plus;
   logic [NBITS-1:0] pc_branch;
   logic [NBITS-1:0] pc_jump;
   logic [NBITS-1:0] ppc;
   logic             cond;
   logic             taken;
   logic             irq_q;
   logic             rise;
   logic             irq_req;
   logic             pending;
   logic             trap;
   logic             link;

   branch_cond u_cond (
      .funct3 (bus.funct3),
      .Zero   (bus.Zero),
      .Neg    (bus.Neg),
      .Carry  (bus.Carry),
      .taken  (cond)
   );

   // IMM is already NBITS wide, so a plain modular add is the
   // sign-extended offset add.
   assign pc_plus   = pc + STEP;
   assign pc_branch = pc + bus.IMM;
   assign pc_jump   = (bus.PCReg + bus.IMM) & ~BIT0;
   assign taken     = bus.Branch & cond;

   always_comb begin
      ppc = pc_plus;
      if (bus.jr)
         ppc = pc_jump;
      else if (bus.ju || taken)
         ppc = pc_branch;
   end

   assign rise    = bus.interrupt & ~irq_q;
   assign irq_req = (IRQ_EDGE != 0) ? (pending | rise)
                                    : bus.interrupt;

   // Return is checked before entry, so a request arriving with tret
   // is taken only after the instruction at sepc has executed.
   always_comb begin
      pc_n    = ppc;
      state_n = state;
      trap    = 1'b0;
      if (reset) begin
         pc_n    = PC_RST;
         state_n = RUN;
      end else if (bus.busy) begin
         pc_n = pc;
      end else if (state == HANDLER && bus.tret) begin
         pc_n    = sepc;
         state_n = RUN;
      end else if (state == RUN && irq_req) begin
         pc_n    = VEC;
         state_n = HANDLER;
         trap    = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset)
         state <= RUN;
      else
         state <= state_n;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pc      <= PC_RST;
         sepc    <= '0;
         pending <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         pc    <= pc_n;
         irq_q <= bus.interrupt;
         if (trap)
            sepc <= ppc;
         if (IRQ_EDGE == 0)
            pending <= 1'b0;
         else if (trap)
            pending <= 1'b0;
         else if (rise)
            pending <= 1'b1;
      end
   end

   assign link = (bus.ju | bus.jr) & ~bus.busy & ~reset;

   assign bus.pc         = pc;
   assign bus.pc_        = pc_n;
   assign bus.link       = link;
   assign bus.pclink     = link ? pc_plus : '0;
   assign bus.sepc       = sepc;
   assign bus.in_handler = (state == HANDLER);
   assign bus.pending    = pending;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: level-mode and edge-mode instances.
// Inputs change just after negedge; outputs are checked before posedge.
module tb_pc_sequencer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [6:0] bt [11];

   always #50 clock = ~clock;

   pc_sequencer_if #(.NBITS(8)) lv ();
   pc_sequencer_if #(.NBITS(8)) ed ();

   pc_sequencer #(
      .NBITS(8), .RESET_PC(32'h0), .IVEC(32'h40),
      .ISTEP(4), .IRQ_EDGE(0)
   ) u_lvl (
      .clock (clock),
      .reset (reset),
      .bus   (lv)
   );

   pc_sequencer #(
      .NBITS(8), .RESET_PC(32'h0), .IVEC(32'h40),
      .ISTEP(4), .IRQ_EDGE(1)
   ) u_edg (
      .clock (clock),
      .reset (reset),
      .bus   (ed)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      lv.busy = 0; lv.interrupt = 0; lv.Branch = 0;
      lv.funct3 = 0; lv.Zero = 0; lv.Neg = 0; lv.Carry = 0;
      lv.ju = 0; lv.jr = 0; lv.tret = 0;
      lv.IMM = 0; lv.PCReg = 0;
      ed.busy = 0; ed.interrupt = 0; ed.Branch = 0;
      ed.funct3 = 0; ed.Zero = 0; ed.Neg = 0; ed.Carry = 0;
      ed.ju = 0; ed.jr = 0; ed.tret = 0;
      ed.IMM = 0; ed.PCReg = 0;
   endtask

   initial begin
      // {funct3, Zero, Neg, Carry, taken}
      bt = '{
         7'b000_100_1, 7'b000_000_0,
         7'b001_000_1, 7'b001_100_0,
         7'b100_010_1, 7'b101_010_0,
         7'b110_000_1, 7'b111_000_0,
         7'b111_001_1, 7'b010_111_0,
         7'b011_000_0
      };
      idle();
      reset = 1;
      tick();

      // reset state and outputs held during reset
      lv.ju = 1; lv.IMM = 8'h08;
      settle();
      check("rst_pc_", lv.pc_, 8'h00);
      check("rst_link", lv.link, 0);
      check("rst_pclink", lv.pclink, 8'h00);
      lv.ju = 0;
      check("rst_pc", lv.pc, 8'h00);
      check("rst_sepc", lv.sepc, 8'h00);
      check("rst_hdl", lv.in_handler, 0);
      check("rst_pend", ed.pending, 0);

      // sequential fetch 0,4,8,12
      reset = 0;
      settle();
      check("seq_pc_", lv.pc_, 8'h04);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check("seq_pc", lv.pc, 4 * k);
      end
      reset = 1;
      settle();
      check("rst2_pc_", lv.pc_, 8'h00);
      tick();
      check("rst2_pc", lv.pc, 8'h00);
      check("rst2_sepc", lv.sepc, 8'h00);
      check("rst2_hdl", lv.in_handler, 0);
      reset = 0;

      // JAL to 16
      lv.ju = 1; lv.IMM = 8'h10;
      settle();
      check("jal_pc_", lv.pc_, 8'h10);
      check("jal_link", lv.link, 1);
      check("jal_pclink", lv.pclink, 8'h04);
      tick();
      lv.ju = 0;
      check("jal_pc", lv.pc, 8'h10);

      // branch conditions at pc=16, IMM=-8
      lv.Branch = 1; lv.IMM = 8'hF8;
      for (int i = 0; i < 11; i++) begin
         lv.funct3 = bt[i][6:4];
         lv.Zero   = bt[i][3];
         lv.Neg    = bt[i][2];
         lv.Carry  = bt[i][1];
         settle();
         check($sformatf("br%0d", i), lv.pc_,
               bt[i][0] ? 8'h08 : 8'h14);
      end
      lv.Branch = 0; lv.funct3 = 3'b000; lv.Zero = 1;
      settle();
      check("nobr_pc_", lv.pc_, 8'h14);
      idle();
      tick();
      check("pc20", lv.pc, 8'h14);

      // JALR with and without busy
      lv.jr = 1; lv.PCReg = 8'h33; lv.IMM = 8'h02;
      settle();
      check("jalr_pc_", lv.pc_, 8'h34);
      check("jalr_link", lv.link, 1);
      check("jalr_pclink", lv.pclink, 8'h18);
      lv.busy = 1;
      settle();
      check("busy_pc_", lv.pc_, 8'h14);
      check("busy_link", lv.link, 0);
      check("busy_pclink", lv.pclink, 8'h00);
      tick();
      check("busy_pc", lv.pc, 8'h14);
      lv.busy = 0;
      tick();
      check("jalr_pc", lv.pc, 8'h34);
      lv.ju = 1; lv.PCReg = 8'h10; lv.IMM = 8'h00;
      settle();
      check("jr_prio", lv.pc_, 8'h10);
      idle();

      // level interrupt at pc=8
      reset = 1;
      tick();
      reset = 0;
      lv.ju = 1; lv.IMM = 8'h08;
      tick();
      idle();
      check("l_pc8", lv.pc, 8'h08);
      lv.interrupt = 1;
      settle();
      check("l_trap_pc_", lv.pc_, 8'h40);
      tick();
      check("l_trap_pc", lv.pc, 8'h40);
      check("l_sepc", lv.sepc, 8'h0C);
      check("l_hdl", lv.in_handler, 1);
      settle();
      check("l_nest_pc_", lv.pc_, 8'h44);
      tick();
      check("l_nest_pc", lv.pc, 8'h44);
      check("l_nest_hdl", lv.in_handler, 1);
      check("l_nest_sepc", lv.sepc, 8'h0C);
      check("l_pend", lv.pending, 0);
      lv.tret = 1;
      settle();
      check("l_ret_pc_", lv.pc_, 8'h0C);
      tick();
      check("l_ret_pc", lv.pc, 8'h0C);
      check("l_ret_hdl", lv.in_handler, 0);
      lv.tret = 0;
      settle();
      check("l_re_pc_", lv.pc_, 8'h40);
      tick();
      check("l_re_sepc", lv.sepc, 8'h10);
      check("l_re_hdl", lv.in_handler, 1);
      lv.interrupt = 0; lv.tret = 1;
      tick();
      check("l_ret2_pc", lv.pc, 8'h10);
      settle();
      check("l_tret_run", lv.pc_, 8'h14);
      tick();
      check("l_tret_hdl", lv.in_handler, 0);

      // trap with a JAL in flight: sepc gets the jump target
      lv.tret = 0; lv.interrupt = 1;
      lv.ju = 1; lv.IMM = 8'h08;
      settle();
      check("l_tj_pc_", lv.pc_, 8'h40);
      check("l_tj_link", lv.link, 1);
      check("l_tj_pclink", lv.pclink, 8'h18);
      tick();
      check("l_tj_sepc", lv.sepc, 8'h1C);
      idle();

      // reset inside the handler
      reset = 1;
      tick();
      check("l_rh_hdl", lv.in_handler, 0);
      check("l_rh_pc", lv.pc, 8'h00);
      check("l_rh_sepc", lv.sepc, 8'h00);
      reset = 0;

      // wrap both ways
      lv.ju = 1; lv.IMM = 8'hFC;
      settle();
      check("neg_jal_pc_", lv.pc_, 8'hFC);
      tick();
      lv.ju = 0;
      check("pcFC", lv.pc, 8'hFC);
      settle();
      check("wrap_pc_", lv.pc_, 8'h00);
      tick();
      check("wrap_pc", lv.pc, 8'h00);

      // edge mode
      reset = 1;
      tick();
      reset = 0;
      ed.busy = 1; ed.interrupt = 1;
      settle();
      check("e_busy_pc_", ed.pc_, 8'h00);
      tick();
      check("e_pend", ed.pending, 1);
      check("e_pend_pc", ed.pc, 8'h00);
      check("e_pend_hdl", ed.in_handler, 0);
      ed.interrupt = 0;
      tick();
      check("e_hold", ed.pending, 1);
      ed.busy = 0;
      settle();
      check("e_trap_pc_", ed.pc_, 8'h40);
      tick();
      check("e_trap_pc", ed.pc, 8'h40);
      check("e_trap_hdl", ed.in_handler, 1);
      check("e_clr", ed.pending, 0);
      check("e_sepc", ed.sepc, 8'h04);
      ed.interrupt = 1;
      settle();
      check("e_nest_pc_", ed.pc_, 8'h44);
      tick();
      check("e_pend2", ed.pending, 1);
      check("e_nest_hdl", ed.in_handler, 1);
      ed.interrupt = 0; ed.tret = 1;
      settle();
      check("e_ret_pc_", ed.pc_, 8'h04);
      tick();
      check("e_ret_pc", ed.pc, 8'h04);
      check("e_ret_hdl", ed.in_handler, 0);
      check("e_ret_pend", ed.pending, 1);
      ed.tret = 0;
      settle();
      check("e_re_pc_", ed.pc_, 8'h40);
      tick();
      check("e_re_sepc", ed.sepc, 8'h08);
      check("e_re_pend", ed.pending, 0);
      check("e_re_hdl", ed.in_handler, 1);

      // rise in RUN is taken at once; a held level does not retrigger
      ed.tret = 1;
      tick();
      ed.tret = 0; ed.interrupt = 1;
      settle();
      check("e_imm_pc_", ed.pc_, 8'h40);
      tick();
      check("e_imm_hdl", ed.in_handler, 1);
      check("e_imm_pend", ed.pending, 0);
      check("e_imm_sepc", ed.sepc, 8'h0C);
      ed.tret = 1;
      tick();
      ed.tret = 0;
      settle();
      check("e_lvl_pc_", ed.pc_, 8'h10);
      tick();
      check("e_lvl_hdl", ed.in_handler, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
